// File: rtl/inst_rx_ctrl.sv
// -----------------------------------------------------------------------------
// inst_rx_ctrl
//
// Turns a stream of received UART bytes into 8-bit sequencer instructions.
// Each frame is two ASCII hex digits (high nibble first) followed by CR or LF.
// Decoded bytes are queued in a small FIFO. They are issued one at a time,
// with a minimum spacing between issue strobes. Issue stalls while the
// sequencer reports busy.
//
// Parameters
//   FIFO_DEPTH  instruction buffer entries (power of two, 2..16)
//   GAP_CYCLES  minimum clk cycles between consecutive o_inst_valid (1..255)
//
// Ports
//   clk           system clock
//   arst_n        asynchronous active-low reset
//   i_rx_data     received byte
//   i_rx_valid    one-cycle strobe qualifying i_rx_data
//   i_seq_busy    high blocks instruction issue
//   o_inst        last issued instruction (held between issues)
//   o_inst_valid  one-cycle issue strobe
//   o_fifo_empty  instruction buffer empty
//   o_fifo_full   instruction buffer full
//   o_inst_cnt    issued-instruction count, wraps 255 -> 0
//   o_err_cnt     saturating error count (only with INST_RX_ERRCNT_EN)
//
// Build option
//   INST_RX_ERRCNT_EN  when defined, adds the o_err_cnt port and its counter.
//                      Errors are discarded identically either way.
// -----------------------------------------------------------------------------
module inst_rx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    input  logic       i_seq_busy,
    output logic [7:0] o_inst,
    output logic       o_inst_valid,
    output logic       o_fifo_empty,
    output logic       o_fifo_full,
`ifdef INST_RX_ERRCNT_EN
    output logic [7:0] o_inst_cnt,
    output logic [7:0] o_err_cnt
`else
    output logic [7:0] o_inst_cnt
`endif
);

    localparam int          PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  GAP_LOAD = 8'(GAP_CYCLES);

    // -------------------------------------------------------------------------
    // Character classification
    // -------------------------------------------------------------------------
    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == 8'h0D) || (c == 8'h0A);
    endfunction

    // Digits carry their value in the low nibble. Both letter ranges have
    // 'A'/'a' at low nibble 1, so adding 9 gives 10..15.
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        if (c[6]) begin
            return 4'(c[3:0] + 4'd9);
        end
        return c[3:0];
    endfunction

    // -------------------------------------------------------------------------
    // Frame parser
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_HI  = 2'd0,
        S_LO  = 2'd1,
        S_END = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       latch_hi;
    logic       latch_lo;
    logic       push_req;
    logic       parse_err;
    logic [3:0] hi_nib;
    logic [3:0] lo_nib;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_rx_valid) begin
            case (state)
                S_HI:    if (is_hex(i_rx_data)) state_nxt = S_LO;
                S_LO:    state_nxt = is_hex(i_rx_data) ? S_END : S_HI;
                S_END:   state_nxt = S_HI;
                default: state_nxt = S_HI;
            endcase
        end
    end

    always_comb begin
        latch_hi  = 1'b0;
        latch_lo  = 1'b0;
        push_req  = 1'b0;
        parse_err = 1'b0;
        if (i_rx_valid) begin
            case (state)
                S_HI: begin
                    // Stray CR/LF between frames is silently ignored.
                    if (is_hex(i_rx_data)) begin
                        latch_hi = 1'b1;
                    end else if (!is_term(i_rx_data)) begin
                        parse_err = 1'b1;
                    end
                end
                S_LO: begin
                    if (is_hex(i_rx_data)) begin
                        latch_lo = 1'b1;
                    end else begin
                        parse_err = 1'b1;
                    end
                end
                S_END: begin
                    if (is_term(i_rx_data)) begin
                        push_req = 1'b1;
                    end else begin
                        parse_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Nibble holding registers are pure data. A stale value can never be
    // pushed, because a push is only reachable through both latch states.
    always_ff @(posedge clk) begin
        if (latch_hi) hi_nib <= hex_val(i_rx_data);
        if (latch_lo) lo_nib <= hex_val(i_rx_data);
    end

    // -------------------------------------------------------------------------
    // Instruction FIFO (extra pointer bit separates full from empty)
    // -------------------------------------------------------------------------
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           fifo_empty;
    logic           fifo_full;
    logic           gap_ok;
    logic           pop;
    logic           push;
    logic           drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {PTR_W{1'b0}}});

    assign pop  = !fifo_empty && gap_ok && !i_seq_busy;
    // When the FIFO is full, a same-cycle pop frees the head slot for the
    // incoming byte.
    assign push = push_req && (!fifo_full || pop);
    assign drop = push_req && fifo_full && !pop;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full, push and pop can hit the same slot. The issue register
    // samples the old head before this write lands.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= {hi_nib, lo_nib};
    end

    assign o_fifo_empty = fifo_empty;
    assign o_fifo_full  = fifo_full;

    // -------------------------------------------------------------------------
    // Issue spacing
    // -------------------------------------------------------------------------
    // The counter is loaded with GAP_CYCLES on the pop edge, which is the
    // same edge that raises o_inst_valid. It reaches zero GAP_CYCLES cycles
    // after that strobe. The pop for the next strobe happens one edge
    // earlier, so a pop is allowed once the counter is at 1 or below.
    logic [7:0] gap_cnt;

    assign gap_ok = (gap_cnt <= 8'd1);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            gap_cnt <= 8'd0;
        end else if (pop) begin
            gap_cnt <= GAP_LOAD;
        end else if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Issue register stage: FIFO head -> o_inst / o_inst_valid
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_inst       <= 8'h00;
            o_inst_valid <= 1'b0;
            o_inst_cnt   <= 8'h00;
        end else begin
            o_inst_valid <= pop;
            if (pop) begin
                o_inst     <= mem[rd_ptr[PTR_W-1:0]];
                o_inst_cnt <= o_inst_cnt + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Error accounting
    // -------------------------------------------------------------------------
`ifdef INST_RX_ERRCNT_EN
    // A parse error and a full-FIFO drop cannot happen in the same cycle:
    // a drop needs a valid terminator in S_END, and that is not a parse error.
    logic err_evt;

    assign err_evt = parse_err | drop;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_err_cnt <= 8'h00;
        end else if (err_evt && (o_err_cnt != 8'hFF)) begin
            o_err_cnt <= o_err_cnt + 8'd1;
        end
    end
`else
    // Without the counter, error events only discard data.
    logic unused_err;

    assign unused_err = parse_err | drop;
`endif

endmodule

// File: tb/tb_inst_rx_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for inst_rx_ctrl.
// A queue-based behavioural model predicts every output on every cycle.
// Directed scenarios add literal expectations, and a randomized phase
// exercises mixed traffic, busy stalls, overflow and mid-stream resets.
// -----------------------------------------------------------------------------
module tb_inst_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int GAP   = 16;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       seq_busy = 1'b0;
    logic [7:0] o_inst;
    logic       o_inst_valid;
    logic       o_fifo_empty;
    logic       o_fifo_full;
    logic [7:0] o_inst_cnt;
`ifdef INST_RX_ERRCNT_EN
    logic [7:0] o_err_cnt;
`endif

    always #5 clk = ~clk;

    inst_rx_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_seq_busy   (seq_busy),
        .o_inst       (o_inst),
        .o_inst_valid (o_inst_valid),
        .o_fifo_empty (o_fifo_empty),
        .o_fifo_full  (o_fifo_full),
`ifdef INST_RX_ERRCNT_EN
        .o_inst_cnt   (o_inst_cnt),
        .o_err_cnt    (o_err_cnt)
`else
        .o_inst_cnt   (o_inst_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    byte unsigned q[$];
    logic [7:0]   m_inst  = 8'h00;
    logic         m_valid = 1'b0;
    logic [7:0]   m_cnt   = 8'h00;
    logic [7:0]   m_err   = 8'h00;
    int           m_len   = 0;      // hex digits collected in current frame
    logic [7:0]   m_frame = 8'h00;
    longint       m_cyc   = 0;
    longint       m_last  = -1000;  // cycle of last issue strobe
    bit           m_pop;
    bit           m_push;

    function automatic bit c_hex(input logic [7:0] c);
        return (c inside {[8'h30:8'h39], [8'h41:8'h46], [8'h61:8'h66]});
    endfunction

    function automatic bit c_term(input logic [7:0] c);
        return (c == 8'h0D) || (c == 8'h0A);
    endfunction

    function automatic logic [3:0] c_val(input logic [7:0] c);
        if (c <= 8'h39) return 4'(c - 8'h30);
        if (c <= 8'h46) return 4'(c - 8'h37);
        return 4'(c - 8'h57);
    endfunction

    function automatic void m_bump_err();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q.delete();
            m_inst  = 8'h00;
            m_valid = 1'b0;
            m_cnt   = 8'h00;
            m_err   = 8'h00;
            m_len   = 0;
            m_last  = -1000;
        end else begin
            m_cyc++;
            m_pop  = (q.size() > 0) && !seq_busy && (m_cyc - m_last >= GAP);
            m_push = 1'b0;
            if (rx_valid) begin
                if (m_len == 0) begin
                    if (c_hex(rx_data)) begin
                        m_frame[7:4] = c_val(rx_data);
                        m_len = 1;
                    end else if (!c_term(rx_data)) begin
                        m_bump_err();
                    end
                end else if (m_len == 1) begin
                    if (c_hex(rx_data)) begin
                        m_frame[3:0] = c_val(rx_data);
                        m_len = 2;
                    end else begin
                        m_bump_err();
                        m_len = 0;
                    end
                end else begin
                    if (c_term(rx_data)) m_push = 1'b1;
                    else m_bump_err();
                    m_len = 0;
                end
            end
            m_valid = m_pop;
            if (m_pop) begin
                m_inst = q.pop_front();
                m_cnt  = m_cnt + 8'd1;
                m_last = m_cyc;
            end
            if (m_push) begin
                if (q.size() == DEPTH) m_bump_err();
                else q.push_back(m_frame);
            end
        end
    end

    // Per-cycle compare, away from the active edge
    always @(negedge clk) begin
        check("inst",       o_inst,       m_inst);
        check("inst_valid", o_inst_valid, m_valid);
        check("inst_cnt",   o_inst_cnt,   m_cnt);
        check("fifo_empty", o_fifo_empty, (q.size() == 0));
        check("fifo_full",  o_fifo_full,  (q.size() == DEPTH));
`ifdef INST_RX_ERRCNT_EN
        check("err_cnt",    o_err_cnt,    m_err);
`endif
    end

    // Strobe recorder for directed scenarios
    int         tcyc = 0;
    int         st_t[$];
    logic [7:0] st_v[$];

    always @(posedge clk) tcyc <= tcyc + 1;

    always @(negedge clk) begin
        if (o_inst_valid) begin
            st_t.push_back(tcyc);
            st_v.push_back(o_inst);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] hexchar(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
    endfunction

    task automatic send_frame(input logic [7:0] v, input bit lower, input bit lf);
        send_byte(hexchar(v[7:4], lower));
        send_byte(hexchar(v[3:0], lower));
        send_byte(lf ? 8'h0A : 8'h0D);
    endtask

    task automatic pulse_reset(input int n);
        arst_n = 1'b0;
        idle(n);
        arst_n = 1'b1;
    endtask

    task automatic wait_strobes(input string nm, input int n, input int budget);
        int k = 0;
        while (st_v.size() < n && k < budget) begin
            tick();
            k++;
        end
        n_vec++;
        if (st_v.size() < n) begin
            n_err++;
            $display("FAIL %s: %0d strobes seen, expected %0d within %0d cycles",
                     nm, st_v.size(), n, budget);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    initial begin
        byte unsigned pend[$];
        logic [7:0]   v;

        // Reset state
        idle(3);
        check("rst_empty", o_fifo_empty, 1);
        check("rst_full",  o_fifo_full,  0);
        check("rst_inst",  o_inst,       8'h00);
        check("rst_valid", o_inst_valid, 0);
        check("rst_cnt",   o_inst_cnt,   0);
        arst_n = 1'b1;
        idle(2);

        // "3","A",CR -> 0x3A
        st_v.delete(); st_t.delete();
        send_frame(8'h3A, 1'b0, 1'b0);
        check("push_visible", o_fifo_empty, 0);
        wait_strobes("frame_3A", 1, 10);
        if (st_v.size() >= 1) check("frame_3A_val", st_v[0], 8'h3A);
        idle(1);
        check("frame_3A_cnt", o_inst_cnt, 1);

        // "f","f",LF then "0","1",CR back-to-back -> strobes GAP apart
        idle(GAP + 4);
        st_v.delete(); st_t.delete();
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h01, 1'b0, 1'b0);
        wait_strobes("gap_pair", 2, 60);
        if (st_v.size() >= 2) begin
            check("gap_first",   st_v[0], 8'hFF);
            check("gap_second",  st_v[1], 8'h01);
            check("gap_spacing", st_t[1] - st_t[0], 16);
        end

        // "3","G",CR then "1","2",CR -> only 0x12
        idle(GAP + 4);
        st_v.delete(); st_t.delete();
        send_byte(8'h33); send_byte(8'h47); send_byte(8'h0D);
        send_frame(8'h12, 1'b0, 1'b0);
        wait_strobes("bad_frame", 1, 20);
        idle(40);
        check("bad_frame_count", st_v.size(), 1);
        if (st_v.size() >= 1) check("bad_frame_val", st_v[0], 8'h12);
`ifdef INST_RX_ERRCNT_EN
        check("bad_frame_err", o_err_cnt, 1);
`endif

        // Busy held, 5 frames into a 4-deep FIFO
        seq_busy = 1'b1;
        st_v.delete(); st_t.delete();
        send_frame(8'hA1, 1'b0, 1'b0);
        send_frame(8'hB2, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b1);
        send_frame(8'hD4, 1'b1, 1'b0);
        send_frame(8'hE5, 1'b0, 1'b0);
        idle(2);
        check("ovf_full",  o_fifo_full, 1);
        check("ovf_stall", st_v.size(), 0);
`ifdef INST_RX_ERRCNT_EN
        check("ovf_err",   o_err_cnt, 2);
`endif
        seq_busy = 1'b0;
        wait_strobes("ovf_drain", 4, 4 * GAP + 20);
        idle(2 * GAP);
        check("ovf_drain_count", st_v.size(), 4);
        if (st_v.size() >= 4) begin
            check("ovf_v0", st_v[0], 8'hA1);
            check("ovf_v1", st_v[1], 8'hB2);
            check("ovf_v2", st_v[2], 8'hC3);
            check("ovf_v3", st_v[3], 8'hD4);
        end
        check("ovf_empty", o_fifo_empty, 1);

        // Partial frame discarded by reset
        send_byte(8'h34);
        pulse_reset(2);
        st_v.delete(); st_t.delete();
        send_frame(8'h56, 1'b0, 1'b0);
        wait_strobes("rst_mid", 1, 10);
        idle(GAP + 4);
        check("rst_mid_count", st_v.size(), 1);
        if (st_v.size() >= 1) check("rst_mid_val", st_v[0], 8'h56);
        check("rst_mid_cnt", o_inst_cnt, 1);

        // 256 frames -> count wraps to zero
        pulse_reset(1);
        for (int i = 0; i < 256; i++) begin
            st_v.delete(); st_t.delete();
            send_frame(8'(i), i[0], i[1]);
            wait_strobes("wrap_frame", 1, GAP + 10);
        end
        idle(2);
        check("wrap_cnt",  o_inst_cnt, 0);
        check("wrap_last", o_inst, 8'hFF);

        // CR/LF-only traffic -> nothing issued, no errors
        idle(GAP + 2);
        st_v.delete(); st_t.delete();
        for (int i = 0; i < 20; i++) begin
            send_byte(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
            idle($urandom_range(0, 2));
        end
        idle(GAP + 4);
        check("term_only_count", st_v.size(), 0);
        check("term_only_empty", o_fifo_empty, 1);
`ifdef INST_RX_ERRCNT_EN
        check("term_only_err", o_err_cnt, 0);
`endif

        // Randomized traffic, checked by the per-cycle model
        for (int c = 0; c < 4000; c++) begin
            if (pend.size() == 0) begin
                if ($urandom_range(0, 99) < 85) begin
                    v = 8'($urandom);
                    pend.push_back(hexchar(v[7:4], $urandom_range(0, 1) != 0));
                    pend.push_back(hexchar(v[3:0], $urandom_range(0, 1) != 0));
                    pend.push_back(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
                end else begin
                    pend.push_back(8'($urandom));
                end
            end
            if ($urandom_range(0, 99) < 5) seq_busy = ~seq_busy;
            if ($urandom_range(0, 999) < 3) begin
                rx_valid = 1'b0;
                pulse_reset($urandom_range(1, 3));
            end
            if ($urandom_range(0, 99) < 60) begin
                rx_data  = pend.pop_front();
                rx_valid = 1'b1;
            end else begin
                rx_data  = 8'($urandom);
                rx_valid = 1'b0;
            end
            tick();
        end
        rx_valid = 1'b0;
        seq_busy = 1'b0;
        idle(DEPTH * (GAP + 2) + 10);
        check("final_empty", o_fifo_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_rx_ctrl.md
INST_RX_CTRL -- requirements
Module: inst_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, instruction buffer entries; legal values are powers of two, 2..16.
REQ-002 Parameter GAP_CYCLES, default 16, minimum clk cycles from one o_inst_valid pulse to the next; legal range 1..255.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 arst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_rx_data  in  8  received UART byte.
REQ-006 i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data.
REQ-007 i_seq_busy  in  1  sequencer/UART-tx busy; high blocks issue.
REQ-008 o_inst  out  8  instruction word to sequencer.
REQ-009 o_inst_valid  out  1  one-cycle issue strobe.
REQ-010 o_fifo_empty  out  1  buffer empty flag.
REQ-011 o_fifo_full  out  1  buffer full flag.
REQ-012 o_inst_cnt  out  8  issued-instruction count, wraps 255->0.
REQ-013 o_err_cnt  out  8  error count; present only per REQ-030.

Function
REQ-014 Frame = two ASCII hex digits (0-9, A-F, a-f), high nibble first, then terminator CR (0x0D) or LF (0x0A); decoded value = 8-bit instruction.
REQ-015 Parser states S_HI, S_LO, S_END; reset state S_HI; advances only on cycles with i_rx_valid=1.
REQ-016 S_HI: hex -> latch high nibble, go S_LO; CR/LF -> ignore, stay S_HI; other -> error, stay S_HI.
REQ-017 S_LO: hex -> latch low nibble, go S_END; any other -> error, discard frame, go S_HI.
REQ-018 S_END: CR/LF -> push decoded byte, go S_HI; other -> error, discard frame, go S_HI.
REQ-019 Push visible in FIFO (o_fifo_empty falls) the cycle after the terminator strobe.
REQ-020 Push while full and no same-cycle pop -> byte dropped, counted as error; FIFO contents unchanged.
REQ-021 Same-cycle push and pop when full -> both performed; occupancy unchanged; no error.
REQ-022 Issue condition: FIFO non-empty, gap counter zero, i_seq_busy=0; on that cycle pop head, next cycle o_inst=head value and o_inst_valid=1 for exactly one cycle.
REQ-023 o_inst holds last issued value until next issue.
REQ-024 Gap counter loads GAP_CYCLES on issue, decrements to zero; next issue no earlier than GAP_CYCLES cycles after previous o_inst_valid.
REQ-025 i_seq_busy rising while FIFO non-empty stalls issue only; already-asserted o_inst_valid is not retracted.
REQ-026 o_inst_cnt increments by one per o_inst_valid; 255 wraps to 0.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit or occupancy counter.

Reset
REQ-028 arst_n=0 immediately forces: parser S_HI, FIFO empty (o_fifo_empty=1, o_fifo_full=0), gap counter 0, o_inst=0x00, o_inst_valid=0, o_inst_cnt=0, o_err_cnt=0.
REQ-029 Reset mid-frame or mid-issue discards partial frame and all buffered entries; the first i_rx_valid after deassertion is parsed from S_HI.

Configuration
REQ-030 Macro INST_RX_ERRCNT_EN defined: o_err_cnt exists, increments once per error event (REQ-016/017/018/020), saturates at 255. Undefined: o_err_cnt port and counter logic absent; errors still discard per REQ-016..020.

Verification
REQ-031 Bytes "3","A",CR -> one o_inst_valid with o_inst=0x3A; o_inst_cnt=1.
REQ-032 "f","f",LF then "0","1",CR back-to-back, GAP_CYCLES=16 -> 0xFF then 0x01, strobes exactly 16 cycles apart.
REQ-033 "3","G",CR then "1","2",CR -> only 0x12 issued; o_err_cnt=1 (macro on).
REQ-034 i_seq_busy=1 held; send 5 valid frames, FIFO_DEPTH=4 -> o_fifo_full=1, 5th dropped, o_err_cnt=1; release busy -> first 4 values issued in order, then o_fifo_empty=1.
REQ-035 Send "4" then assert arst_n=0 for 2 cycles, then "5","6",CR -> single issue 0x56, o_inst_cnt=1.
REQ-036 256 valid frames -> o_inst_cnt returns to 0; CR/LF-only traffic -> no issue, no error.
